// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the single-port memory bus.
// Takes one read/write command at a time on a valid/ready port, drives one
// registered bus access, and returns read data on a valid/ready response port.
// Out-of-range reads are answered locally with an error response; out-of-range
// writes are silently dropped. Access counters saturate instead of wrapping.

module mem_bus_master #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wr_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RSP     = 2'd3
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                wr_done_q;
  logic                mem_en_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    wr_count_q;
  logic [CNT_W-1:0]    rd_count_q;

  logic                accept;
  logic                addr_ok;
  logic [CNT_W-1:0]    wr_count_d;
  logic [CNT_W-1:0]    rd_count_d;

  assign accept  = cmd_valid & cmd_ready_q;
  assign addr_ok = 32'(cmd_addr) < 32'(DEPTH);

  // Saturating increments: once all ones, the counters stick.
  always_comb begin
    wr_count_d = (wr_count_q == {CNT_W{1'b1}}) ? wr_count_q : wr_count_q + CNT_W'(1);
    rd_count_d = (rd_count_q == {CNT_W{1'b1}}) ? rd_count_q : rd_count_q + CNT_W'(1);
  end

  // Command/bus/response sequencer; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      // wr_done is a single-cycle pulse aligned with the write's bus cycle.
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (addr_ok) begin
              mem_en_q    <= 1'b1;
              mem_wr_q    <= cmd_wr;
              mem_addr_q  <= cmd_addr;
              mem_wdata_q <= cmd_wdata;
              wr_done_q   <= cmd_wr;
              cmd_ready_q <= 1'b0;
              state_q     <= ISSUE;
            end else if (!cmd_wr) begin
              // Out-of-range read: answer locally, the bus is never touched.
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              cmd_ready_q <= 1'b0;
              state_q     <= RSP;
            end
            // Out-of-range write: dropped, remain ready.
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (mem_wr_q) begin
            wr_count_q  <= wr_count_d;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Responder output is valid in this cycle (one-cycle read latency).
          rsp_data_q  <= mem_rdata;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rd_count_q  <= rd_count_d;
          state_q     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign wr_done   = wr_done_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule
